// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall control for the 5-stage pipeline.
// Optional FWD_HAZARD_STATS_EN adds saturating stall/forward event counters.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              mem_stall,
    output logic [1:0]        fwd_A,
    output logic [1:0]        fwd_B,
    output logic              stall_id,
    output logic              err
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       fwd_cnt
`endif
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              is_load;
    } stage_t;

    stage_t     ex_q, ex_d, mem_q;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic       hit_e_rs, hit_e_rt, hit_m_rs, hit_m_rt;
    logic       enter_ex;

    assign hit_e_rs = ex_q.v  & ex_q.wr  & (ex_q.rd  == id_rs) & id_rs_used;
    assign hit_e_rt = ex_q.v  & ex_q.wr  & (ex_q.rd  == id_rt) & id_rt_used;
    assign hit_m_rs = mem_q.v & mem_q.wr & (mem_q.rd == id_rs) & id_rs_used;
    assign hit_m_rt = mem_q.v & mem_q.wr & (mem_q.rd == id_rt) & id_rt_used;

    assign stall_id = id_valid & ~flush & ~mem_stall & ex_q.is_load & (hit_e_rs | hit_e_rt);
    assign err      = id_valid & id_is_load & ~id_wr;
    assign enter_ex = id_valid & ~flush & ~stall_id;

    always_comb begin
        // NOTE: every field gets a default so a bubble never carries stale tags.
        ex_d    = '0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (enter_ex) begin
            ex_d.v       = 1'b1;
            ex_d.rd      = id_rd;
            ex_d.wr      = id_wr;
            ex_d.is_load = id_is_load;
            // The EX producer is younger than the MEM one, so it takes priority.
            fwd_a_d = {hit_e_rs, ~hit_e_rs & hit_m_rs};
            fwd_b_d = {hit_e_rt, ~hit_e_rt & hit_m_rt};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else if (!mem_stall) begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_A = fwd_a_q;
    assign fwd_B = fwd_b_q;

`ifdef FWD_HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, fwd_cnt_q;
    logic        fwd_event;

    assign fwd_event = ~mem_stall & enter_ex & ((fwd_a_d | fwd_b_d) != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_id && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (fwd_event && fwd_cnt_q != 16'hFFFF)  fwd_cnt_q   <= fwd_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding, load-use stall, flush, mem_stall, reset.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [2:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       id_rs_used = 1'b0, id_rt_used = 1'b0, id_wr = 1'b0, id_is_load = 1'b0;
    logic       flush = 1'b0, mem_stall = 1'b0;
    logic [1:0] fwd_A, fwd_B;
    logic       stall_id, err;
`ifdef FWD_HAZARD_STATS_EN
    logic [15:0] stall_cnt, fwd_cnt;
`endif

    int errors = 0;
    int checks = 0;

    fwd_hazard_ctrl #(.REG_AW(3)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr(id_wr),
        .id_is_load(id_is_load), .flush(flush), .mem_stall(mem_stall),
        .fwd_A(fwd_A), .fwd_B(fwd_B), .stall_id(stall_id), .err(err)
`ifdef FWD_HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                         input logic rsu, input logic rtu, input logic [2:0] rd,
                         input logic wr, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        id_rd = rd; id_wr = wr; id_is_load = ld;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        flush = 1'b0; mem_stall = 1'b0;
        nop();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Leave junk in flight, then reset while a dependent instruction sits in ID.
        drive(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        step();
        drive(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        nop();
        checks++; if (fwd_A !== 2'b00) begin errors++; $display("FAIL reset_fwdA: got %b want 00", fwd_A); end
        checks++; if (fwd_B !== 2'b00) begin errors++; $display("FAIL reset_fwdB: got %b want 00", fwd_B); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_id); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        // R1 producer must have been discarded by reset.
        drive(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b0000) begin errors++; $display("FAIL reset_tags: got %b want 0000", {fwd_A, fwd_B}); end
    endtask

    task automatic test_err();
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_bad_load: got %b want 1", err); end
        drive(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_good_load: got %b want 0", err); end
        drive(1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_invalid: got %b want 0", err); end
    endtask

    task automatic test_fwd_ex();
        do_reset();
        drive(1'b1, 3'd3, 3'd4, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);   // ADD R1<-R3,R4
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b0000) begin errors++; $display("FAIL ex_first: got %b want 0000", {fwd_A, fwd_B}); end
        drive(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);   // ADD R2<-R1,R3
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL ex_nostall: got %b want 0", stall_id); end
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b1000) begin errors++; $display("FAIL ex_fwd: got %b want 1000", {fwd_A, fwd_B}); end
    endtask

    task automatic test_fwd_mem();
        do_reset();
        drive(1'b1, 3'd3, 3'd4, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);   // ADD R1
        step();
        nop();
        step();
        drive(1'b1, 3'd5, 3'd1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);   // SUB R4<-R5,R1
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b0001) begin errors++; $display("FAIL mem_fwd: got %b want 0001", {fwd_A, fwd_B}); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);   // LD R2
        step();
        drive(1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);   // ADD R3<-R2,R2
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall_id); end
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b0000) begin errors++; $display("FAIL lu_bubble: got %b want 0000", {fwd_A, fwd_B}); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got %b want 0", stall_id); end
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b0101) begin errors++; $display("FAIL lu_fwd: got %b want 0101", {fwd_A, fwd_B}); end
    endtask

    task automatic test_load_use_imm();
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1);   // LD R4
        step();
        drive(1'b1, 3'd6, 3'd4, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);   // ADDI R5<-R6,imm (rt field = R4, unused)
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL lui_nostall: got %b want 0", stall_id); end
        drive(1'b1, 3'd4, 3'd4, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);   // ADDI R5<-R4,imm
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL lui_stall: got %b want 1", stall_id); end
        step();
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b0100) begin errors++; $display("FAIL lui_fwd: got %b want 0100", {fwd_A, fwd_B}); end
    endtask

    task automatic test_youngest();
        do_reset();
        drive(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);   // ADD R1
        step();
        drive(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);   // ADD R1
        step();
        drive(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0);   // ADD R6<-R1,R1
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b1010) begin errors++; $display("FAIL young_fwd: got %b want 1010", {fwd_A, fwd_B}); end
    endtask

    task automatic test_r0_and_invalid();
        do_reset();
        drive(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);   // ADD R0
        step();
        drive(1'b1, 3'd0, 3'd0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);   // ADD R1<-R0,R0
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b1010) begin errors++; $display("FAIL r0_fwd: got %b want 1010", {fwd_A, fwd_B}); end
        do_reset();
        drive(1'b0, 3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);   // invalid slot writing R1
        step();
        drive(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b0000) begin errors++; $display("FAIL invalid_no_tag: got %b want 0000", {fwd_A, fwd_B}); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);   // LD R2
        step();
        flush = 1'b1;
        drive(1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);   // ADD R3<-R2,R2 squashed
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall_id); end
        step();
        flush = 1'b0;
        checks++; if ({fwd_A, fwd_B} !== 4'b0000) begin errors++; $display("FAIL flush_bubble: got %b want 0000", {fwd_A, fwd_B}); end
        drive(1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0);   // reads R3 of squashed ADD
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b0000) begin errors++; $display("FAIL flush_no_tag: got %b want 0000", {fwd_A, fwd_B}); end
    endtask

    task automatic test_mem_stall();
        do_reset();
        drive(1'b1, 3'd3, 3'd4, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);   // ADD R1
        step();
        drive(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);   // ADD R2<-R1,R1
        step();
        mem_stall = 1'b1;
        nop();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({fwd_A, fwd_B} !== 4'b1010) begin errors++; $display("FAIL ms_hold%0d: got %b want 1010", i, {fwd_A, fwd_B}); end
        end
        mem_stall = 1'b0;
        drive(1'b1, 3'd2, 3'd1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);   // ADD R7<-R2,R1
        step();
        checks++; if ({fwd_A, fwd_B} !== 4'b1001) begin errors++; $display("FAIL ms_release: got %b want 1001", {fwd_A, fwd_B}); end
        // Load-use stall is suppressed while memory stalls, and reappears after.
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);   // LD R2
        step();
        mem_stall = 1'b1;
        drive(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL ms_nostall: got %b want 0", stall_id); end
        step();
        mem_stall = 1'b0;
        #1;
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL ms_load_held: got %b want 1", stall_id); end
    endtask

    initial begin
        test_reset();
        test_err();
        test_fwd_ex();
        test_fwd_mem();
        test_load_use();
        test_load_use_imm();
        test_youngest();
        test_r0_and_invalid();
        test_flush();
        test_mem_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
